// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: feeder FSM states and the default
// operand geometry that the feeder and the MAC accumulator both build from.
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 8;
  localparam int MAC_DEPTH      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/op_fifo.sv
// Single-clock operand FIFO. rd_data is a register that carries the popped
// entry for the one cycle after a pop and is zero otherwise.
module op_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  do_wr_s;
  logic                  do_rd_s;

  assign do_wr_s = wr_en && (count_r != CNT_W'(DEPTH));
  assign do_rd_s = rd_en && (count_r != '0);

  // storage array, no reset needed since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // pointers, occupancy and the zero-when-idle read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      rd_data_r <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_rd_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end else begin
        rd_ptr_r  <= rd_ptr_r;
        rd_data_r <= '0;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = rd_data_r;
  assign count   = count_r;
  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == '0);

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder in front of the MAC: buffers A/B operands, then on start
// issues a clear followed by one enabled operand pair per cycle and a done pulse.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int DEPTH      = MAC_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_wr_en,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  b_wr_en,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  start,
  output logic                  a_full,
  output logic                  b_full,
  output logic                  a_empty,
  output logic                  b_empty,
  output logic                  busy,
  output logic                  start_err,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  done
);

  localparam int CNT_W = $clog2(DEPTH+1);

  feeder_state_e    state_r, state_next_s;
  logic [CNT_W-1:0] remaining_r, remaining_next_s;
  logic [CNT_W-1:0] a_count_s, b_count_s;
  logic             start_ok_s, start_err_s, pop_s, wr_gate_s;
  logic             busy_r, start_err_r, mac_clr_r, mac_en_r, done_r;

  // a write in the same cycle as an accepted start must not change N
  assign wr_gate_s = (state_r == IDLE) && !start_ok_s;

  op_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_a_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (a_wr_en && wr_gate_s),
    .wr_data (a_wr_data),
    .rd_en   (pop_s),
    .rd_data (mac_a),
    .full    (a_full),
    .empty   (a_empty),
    .count   (a_count_s)
  );

  op_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_b_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (b_wr_en && wr_gate_s),
    .wr_data (b_wr_data),
    .rd_en   (pop_s),
    .rd_data (mac_b),
    .full    (b_full),
    .empty   (b_empty),
    .count   (b_count_s)
  );

  // next-state, pop request and start qualification
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    pop_s            = 1'b0;
    start_ok_s       = 1'b0;
    start_err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (!a_empty && !b_empty && (a_count_s == b_count_s)) begin
            start_ok_s       = 1'b1;
            remaining_next_s = a_count_s;
            state_next_s     = CLEAR;
          end else begin
            start_err_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        pop_s            = 1'b1;
        remaining_next_s = remaining_r - CNT_W'(1);
        state_next_s     = STREAM;
      end
      STREAM: begin
        if (remaining_r != '0) begin
          pop_s            = 1'b1;
          remaining_next_s = remaining_r - CNT_W'(1);
        end else begin
          state_next_s = FINISH;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // state and registered control outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      busy_r      <= 1'b0;
      start_err_r <= 1'b0;
      mac_clr_r   <= 1'b0;
      mac_en_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      busy_r      <= (state_next_s != IDLE);
      start_err_r <= start_err_s;
      mac_clr_r   <= (state_next_s == CLEAR);
      mac_en_r    <= pop_s;
      done_r      <= (state_next_s == FINISH);
    end
  end

  assign busy      = busy_r;
  assign start_err = start_err_r;
  assign mac_clr   = mac_clr_r;
  assign mac_en    = mac_en_r;
  assign done      = done_r;

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Upstream stage of the MAC accumulator.
- Buffers one row of A operands and one vector of B operands in two internal FIFOs.
- On a start command, issues a one-cycle clear to the MAC, then streams the operand pairs with enable asserted, one pair per cycle.
- Pulses done after the last pair.
- The MAC-side outputs connect directly to the MAC's Clr/En/Ain/Bin.

Parameters:
- DATA_WIDTH, 8: width of each A/B operand.
- DEPTH, 8: entries per FIFO. Must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_wr_en  in  1  push a_wr_data into A FIFO
- a_wr_data  in  DATA_WIDTH  A operand
- b_wr_en  in  1  push b_wr_data into B FIFO
- b_wr_data  in  DATA_WIDTH  B operand
- start  in  1  begin a stream (pulse)
- a_full  out  1  A FIFO holds DEPTH entries
- b_full  out  1  B FIFO holds DEPTH entries
- a_empty  out  1  A FIFO holds 0 entries
- b_empty  out  1  B FIFO holds 0 entries
- busy  out  1  FSM not in IDLE
- start_err  out  1  one-cycle pulse: start rejected
- mac_clr  out  1  clear to MAC
- mac_en  out  1  enable to MAC; mac_a/mac_b valid
- mac_a  out  DATA_WIDTH  A operand to MAC
- mac_b  out  DATA_WIDTH  B operand to MAC
- done  out  1  one-cycle pulse after last pair

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
  - Both FIFOs empty, pointers 0, FSM in IDLE.
  - All outputs 0, except a_empty=1 and b_empty=1.
  - Reset mid-stream aborts immediately and discards FIFO contents. No done is produced.
- FIFO storage and widths:
  - Counts are $clog2(DEPTH+1) bits wide.
  - Read/write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Writes:
  - Accepted only in IDLE and only when that FIFO is not full.
  - Writes while busy or while full are silently dropped; the FIFO is unchanged.
  - A and B writes are independent and may occur in the same cycle.
  - Flags update the cycle after the write edge.
- All MAC-side outputs (mac_clr, mac_en, mac_a, mac_b, done) are registered.
- FSM states: IDLE, CLEAR, STREAM, FINISH.
- IDLE:
  - start is accepted when both FIFOs are non-empty and a_count == b_count.
    - Latch N = a_count.
    - Go to CLEAR.
  - start is rejected when either FIFO is empty or the counts differ.
    - start_err=1 for one cycle.
    - Stay in IDLE; FIFOs unchanged.
  - A write in the same cycle as an accepted start is dropped.
- CLEAR:
  - mac_clr=1 for exactly one cycle, asserted in the cycle after start was sampled.
  - Go to STREAM.
- STREAM:
  - Each cycle, pop one entry from each FIFO.
  - Drive mac_en=1 with mac_a/mac_b = popped values, in the same cycle.
  - Decrement the remaining count.
  - After the N-th pop, go to FINISH.
  - mac_en is high for exactly N consecutive cycles; no bubbles.
  - Pairs are in FIFO order: the first A written pairs with the first B written.
- FINISH:
  - done=1 for one cycle; mac_en=0.
  - Return to IDLE. FIFOs are now empty.
- Timing and outputs outside STREAM:
  - Latency: start sampled at edge k gives mac_clr high in cycle k+1, first mac_en in cycle k+2, last mac_en in cycle k+1+N, done in cycle k+2+N.
  - busy is high from cycle k+1 through the done cycle inclusive.
  - Outside STREAM, mac_en=0 and mac_a/mac_b hold 0. No stale data is driven.
  - start while busy is ignored; no start_err.
  - mac_clr and mac_en are never high in the same cycle.

Decomposition:
- Package mac_pkg:
  - feeder_state_e enum (IDLE, CLEAR, STREAM, FINISH).
  - Default DATA_WIDTH/DEPTH localparams shared with the MAC, so the MAC's 3*DATA_WIDTH accumulator and the feeder agree.
- Sub-module op_fifo:
  - Single-clock FIFO with parameters DATA_WIDTH and DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data (registered), full, empty, count.
  - Instantiated twice, once for A and once for B.
- The feeder top holds the FSM, write gating and output registers.

Test Plan:
- Write A=1,2,3,4 and B=2,2,2,2, pulse start. Expect:
  - mac_clr in the next cycle.
  - Then 4 mac_en cycles with pairs (1,2),(2,2),(3,2),(4,2).
  - done 1 cycle later.
  - A downstream MAC reads 20.
- Write 3 A entries and 2 B entries, pulse start. Expect:
  - start_err pulse.
  - busy stays 0; counts remain 3/2.
- Write 9 entries to each FIFO with DEPTH=8. Expect:
  - full=1 after the 8th write; the 9th write is dropped.
  - Stream yields exactly 8 pairs: the first 8 values in order.
- During STREAM, assert a_wr_en/b_wr_en and start. Expect:
  - Writes dropped; no start_err.
  - Stream completes with N pairs; FIFOs empty at done.
- Run two back-to-back loads and streams so the pointers wrap (5 entries then 6). Expect:
  - Correct FIFO ordering across the wrap.
  - mac_clr precedes each stream.
- Deassert rst_n on the 2nd mac_en cycle of a 4-pair stream. Expect:
  - All outputs 0 immediately; a_empty=b_empty=1.
  - No done pulse.
  - After release, a fresh 1-pair load and stream works.
